// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main control FSM with mem_ready handshake and bus timeout
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_cond_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_source,
  output logic       bus_err,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3, S_WBL = 4'd4,
    S_MWR = 4'd5, S_EXR = 4'd6, S_WBR = 4'd7, S_EXI = 4'd8, S_WBI = 4'd9,
    S_BEQ = 4'd10, S_BNE = 4'd11, S_JMP = 4'd12
  } state_t;
  state_t st, nx;
  logic [7:0] cnt;
  logic mw, to;
  assign mw = st == S_IF || st == S_MRD || st == S_MWR;
  assign to = mw && !mem_ready && cnt == 8'(TIMEOUT - 1);
  assign state = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= S_IF;
      cnt <= '0;
    end else begin
      st  <= nx;
      cnt <= (nx != st || to) ? '0 : (mw && !mem_ready) ? cnt + 8'd1 : cnt;
    end
  always_comb begin
    nx = S_IF;
    case (st)
      S_IF:    nx = mem_ready ? S_ID : S_IF;
      S_ID:    case (op)
                 6'b100011, 6'b101011: nx = S_MADDR;
                 6'b000000: nx = S_EXR;
                 6'b000100: nx = S_BEQ;
                 6'b000101: nx = S_BNE;
                 6'b000010: nx = S_JMP;
                 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: nx = S_EXI;
                 default: nx = S_IF;
               endcase
      S_MADDR: nx = op == 6'b100011 ? S_MRD : S_MWR;
      S_MRD:   nx = mem_ready ? S_WBL : to ? S_IF : S_MRD;
      S_MWR:   nx = mem_ready ? S_IF : to ? S_IF : S_MWR;
      S_EXR:   nx = S_WBR;
      S_EXI:   nx = S_WBI;
      default: nx = S_IF;
    endcase
  end
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    aluop = 2'b00;
    pc_source = 2'b00;
    bus_err = to;
    case (st)
      S_IF:    begin mem_read = 1'b1; alu_src_b = 2'b01; pc_write = mem_ready; ir_write = mem_ready; end
      S_ID:    alu_src_b = 2'b11;
      S_MADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      S_MRD:   begin mem_read = 1'b1; iord = 1'b1; end
      S_MWR:   begin mem_write = 1'b1; iord = 1'b1; end
      S_WBL:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_EXR:   begin alu_src_a = 1'b1; aluop = 2'b10; end
      S_WBR:   begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_EXI:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; aluop = 2'b10; end
      S_WBI:   reg_write = 1'b1;
      S_BEQ:   begin alu_src_a = 1'b1; aluop = 2'b01; pc_source = 2'b01; pc_write_cond = 1'b1; end
      S_BNE:   begin alu_src_a = 1'b1; aluop = 2'b11; pc_source = 2'b01; pc_write_cond_ne = 1'b1; end
      S_JMP:   begin pc_write = 1'b1; pc_source = 2'b10; end
      default: ;
    endcase
    if (!rst_n) begin
      {pc_write, pc_write_cond, pc_write_cond_ne, iord, mem_read, mem_write, ir_write} = '0;
      {reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop, pc_source, bus_err} = '0;
    end
  end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control state machine for the multicycle MIPS CPU.
- Sequences PC, memory, IR, register file and ALU across fetch/decode/execute/memory/writeback.
- Drives the 2-bit aluop consumed by the ALU-control decoder: 00 add, 01 sub (beq), 11 bne-compare, 10 decode from op/funct.
- Adds a memory-ready handshake with a timeout counter so a slow memory stalls the sequence safely.

Parameters:
- TIMEOUT, 15, max cycles to wait for mem_ready in a memory state before aborting (1..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode field of the IR
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- pc_write_cond_ne  out  1  PC load if ALU not-zero (bne)
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_dst  out  1  write register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- aluop  out  2  to ALU-control decoder
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- bus_err  out  1  one-cycle pulse on memory timeout
- state  out  4  current state, for debug

Behaviour:
- Reset: state = IF, wait counter = 0. While rst_n = 0, every output other than state is forced to 0.
- Outputs are a Moore decode of state, except pc_write and ir_write in IF, which are additionally gated by mem_ready. Unlisted outputs in a state are 0.
- IF: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, aluop = 00, pc_source = 00.
  - When mem_ready: ir_write = 1, pc_write = 1, go to ID.
  - Otherwise stay in IF.
- ID: alu_src_a = 0, alu_src_b = 11, aluop = 00 (branch target into ALUOut). Next state by op:
  - 100011 or 101011 -> MADDR
  - 000000 -> EXR
  - 000100 -> BEQ
  - 000101 -> BNE
  - 000010 -> JMP
  - 001000, 001100, 001101, 001110, 001010 -> EXI
  - any other opcode -> IF (treated as a nop; PC has already advanced)
- MADDR: alu_src_a = 1, alu_src_b = 10, aluop = 00. Go to MRD if op = 100011, else to MWR.
- MRD: mem_read = 1, iord = 1. Go to WBL when mem_ready.
- MWR: mem_write = 1, iord = 1. Go to IF when mem_ready.
- WBL: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Go to IF.
- EXR: alu_src_a = 1, alu_src_b = 00, aluop = 10. Go to WBR.
- WBR: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Go to IF.
- EXI: alu_src_a = 1, alu_src_b = 10, aluop = 10. Go to WBI.
- WBI: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Go to IF.
- BEQ: alu_src_a = 1, alu_src_b = 00, aluop = 01, pc_source = 01, pc_write_cond = 1. Go to IF.
- BNE: same as BEQ but aluop = 11 and pc_write_cond_ne = 1 instead of pc_write_cond. Go to IF.
- JMP: pc_write = 1, pc_source = 10. Go to IF.
- Memory wait (IF, MRD, MWR):
  - 8-bit counter increments each cycle mem_ready = 0 and clears on every state change.
  - If the counter reaches TIMEOUT with mem_ready still 0: bus_err pulses for that cycle, no write or load strobes (pc_write, ir_write, reg_write) fire, next state = IF, counter clears.
  - A mem_ready arriving on the same cycle as the timeout wins: the normal transition is taken and bus_err stays 0.
- Strobes stay asserted throughout a wait (mem_read, mem_write and iord remain stable).
- Cycle counts with zero-wait memory: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3.
- Asynchronous reset mid-instruction: immediate return to IF with outputs zeroed. First fetch begins on the first clk edge after deassertion.
- State encoding is fixed:
  - IF = 0, ID = 1, MADDR = 2, MRD = 3, WBL = 4, MWR = 5
  - EXR = 6, WBR = 7, EXI = 8, WBI = 9
  - BEQ = 10, BNE = 11, JMP = 12
  - Codes 13–15 are unreachable; if entered, go to IF on the next clock.

Test Plan:
- lw (op = 100011), mem_ready tied high -> state sequence 0,1,2,3,4,0. reg_write and mem_to_reg are 1 only in state 4. iord = 1 in state 3.
- add (op = 000000) then addi (op = 001000) -> each takes 4 cycles. aluop = 10 in EXR/EXI. reg_dst = 1 in WBR, 0 in WBI.
- beq (000100) then bne (000101) -> 3 cycles each. BEQ: aluop = 01, pc_write_cond = 1. BNE: aluop = 11, pc_write_cond_ne = 1, pc_source = 01.
- sw with mem_ready low for 3 cycles in MWR -> mem_write held for 4 cycles, then IF. No bus_err.
- TIMEOUT = 4, mem_ready never asserted in IF -> bus_err pulses on the 4th wait cycle. ir_write and pc_write stay 0, state remains IF.
- rst_n pulled low while in MRD -> state = 0 and all strobes 0 immediately (asynchronously). Illegal op 111111 after deassertion -> sequence IF, ID, IF.
